// File: rtl/mem_wr_stage_if.sv
// MEM/WB stage bus: memory-stage inputs, stall/flush control, write-back
// results and forwarding-comparator lanes grouped for the pipeline fabric.
interface mem_wr_stage_if #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2
);
    logic                      stall;
    logic                      flush;
    logic                      mem_valid;
    logic [DATA_W-1:0]         mem_dout;
    logic [DATA_W-1:0]         mem_alu_result;
    logic [REG_AW-1:0]         mem_Rw;
    logic                      mem_RegWr;
    logic                      mem_MemtoReg;
    logic [2:0]                mem_LdType;
    logic [NUM_FWD*REG_AW-1:0] fwd_src;

    logic                      wr_valid;
    logic [REG_AW-1:0]         wr_Rw;
    logic                      wr_RegWr;
    logic [DATA_W-1:0]         wr_alu_result;
    logic [DATA_W-1:0]         wr_wdata;
    logic [NUM_FWD-1:0]        fwd_hit;

    modport master (
        output stall, flush, mem_valid, mem_dout, mem_alu_result, mem_Rw,
               mem_RegWr, mem_MemtoReg, mem_LdType, fwd_src,
        input  wr_valid, wr_Rw, wr_RegWr, wr_alu_result, wr_wdata, fwd_hit
    );

    modport slave (
        input  stall, flush, mem_valid, mem_dout, mem_alu_result, mem_Rw,
               mem_RegWr, mem_MemtoReg, mem_LdType, fwd_src,
        output wr_valid, wr_Rw, wr_RegWr, wr_alu_result, wr_wdata, fwd_hit
    );
endinterface

// File: rtl/mem_wr_stage.sv
// MEM/WB pipeline register with stall/flush, little-endian sub-word load
// extraction with sign/zero extension, and write-back forwarding hit detect.
module mem_wr_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2
) (
    input  logic           Clk,
    input  logic           Rst_n,
    mem_wr_stage_if.slave  bus
);
    localparam int OFF_W = $clog2(DATA_W/8);

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] dout;
        logic [DATA_W-1:0] alu;
        logic [REG_AW-1:0] rw;
        logic              regwr;
        logic              memtoreg;
        logic [2:0]        ldtype;
    } stage_t;

    stage_t in_s, st;

    always_comb begin
        in_s.valid    = bus.mem_valid;
        in_s.dout     = bus.mem_dout;
        in_s.alu      = bus.mem_alu_result;
        in_s.rw       = bus.mem_Rw;
        in_s.regwr    = bus.mem_RegWr;
        in_s.memtoreg = bus.mem_MemtoReg;
        in_s.ldtype   = bus.mem_LdType;
    end

    // flush outranks stall; bubble data fields still load but are never used
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            st <= '0;
        end else if (bus.flush) begin
            st          <= in_s;
            st.valid    <= 1'b0;
            st.regwr    <= 1'b0;
            st.memtoreg <= 1'b0;
        end else if (!bus.stall) begin
            st <= in_s;
        end
    end

    logic [OFF_W-1:0]  off;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] ext;

    assign off    = st.alu[OFF_W-1:0];
    assign byte_v = st.dout[{off, 3'b000} +: 8];
    // halfword lane ignores off[0]: misaligned halves silently round down
    assign half_v = st.dout[{off[OFF_W-1:1], 4'b0000} +: 16];

    always_comb begin
        ext = st.dout;
        case (st.ldtype)
            LD_LB:   ext = {{(DATA_W-8){byte_v[7]}}, byte_v};
            LD_LBU:  ext = {{(DATA_W-8){1'b0}}, byte_v};
            LD_LH:   ext = {{(DATA_W-16){half_v[15]}}, half_v};
            LD_LHU:  ext = {{(DATA_W-16){1'b0}}, half_v};
            default: ext = st.dout;
        endcase
    end

    logic wr_en;
    assign wr_en = st.valid & st.regwr & (st.rw != '0);

    assign bus.wr_valid      = st.valid;
    assign bus.wr_Rw         = st.rw;
    assign bus.wr_RegWr      = wr_en;
    assign bus.wr_alu_result = st.alu;
    assign bus.wr_wdata      = st.memtoreg ? ext : st.alu;

    logic [NUM_FWD-1:0] hit;

    for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
        assign hit[i] = wr_en & (st.rw == bus.fwd_src[i*REG_AW +: REG_AW]);
    end

    assign bus.fwd_hit = hit;
endmodule

// File: tb/tb_mem_wr_stage.sv
// Directed bench for mem_wr_stage: 32-bit and 64-bit instances share clock/reset.
module tb_mem_wr_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_wr_stage_if #(.DATA_W(32), .REG_AW(5), .NUM_FWD(2)) b32 ();
    mem_wr_stage_if #(.DATA_W(64), .REG_AW(5), .NUM_FWD(2)) b64 ();

    mem_wr_stage #(.DATA_W(32), .REG_AW(5), .NUM_FWD(2)) dut32 (
        .Clk(clk), .Rst_n(rst_n), .bus(b32));
    mem_wr_stage #(.DATA_W(64), .REG_AW(5), .NUM_FWD(2)) dut64 (
        .Clk(clk), .Rst_n(rst_n), .bus(b64));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv32(input logic v, input logic [31:0] dout, input logic [31:0] alu,
                         input logic [4:0] rw, input logic regwr, input logic m2r,
                         input logic [2:0] ld);
        b32.mem_valid      = v;
        b32.mem_dout       = dout;
        b32.mem_alu_result = alu;
        b32.mem_Rw         = rw;
        b32.mem_RegWr      = regwr;
        b32.mem_MemtoReg   = m2r;
        b32.mem_LdType     = ld;
    endtask

    task automatic drv64(input logic [63:0] dout, input logic [63:0] alu, input logic [2:0] ld);
        b64.mem_valid      = 1'b1;
        b64.mem_dout       = dout;
        b64.mem_alu_result = alu;
        b64.mem_Rw         = 5'd4;
        b64.mem_RegWr      = 1'b1;
        b64.mem_MemtoReg   = 1'b1;
        b64.mem_LdType     = ld;
    endtask

    typedef struct {
        logic [2:0]  ld;
        logic [31:0] alu;
        logic [31:0] exp;
        string       tag;
    } ld_vec_t;

    ld_vec_t lv [7];

    initial begin
        lv[0] = '{3'd1, 32'd3, 32'hFFFFFF80, "lb_off3"};
        lv[1] = '{3'd2, 32'd3, 32'h00000080, "lbu_off3"};
        lv[2] = '{3'd3, 32'd2, 32'hFFFF80FF, "lh_off2"};
        lv[3] = '{3'd4, 32'd1, 32'h00007F01, "lhu_off1"};
        lv[4] = '{3'd0, 32'd0, 32'h80FF7F01, "word"};
        lv[5] = '{3'd1, 32'd0, 32'h00000001, "lb_off0"};
        lv[6] = '{3'd7, 32'd2, 32'h80FF7F01, "ld7_word"};

        b32.stall = 1'b0; b32.flush = 1'b0; b32.fwd_src = '0;
        b64.stall = 1'b0; b64.flush = 1'b0; b64.fwd_src = '0;
        drv32(1'b0, '0, '0, '0, 1'b0, 1'b0, 3'd0);
        drv64('0, '0, 3'd0);

        // reset state
        #2;
        chk("rst_valid", b32.wr_valid, 0);
        chk("rst_rw", b32.wr_Rw, 0);
        chk("rst_regwr", b32.wr_RegWr, 0);
        chk("rst_alu", b32.wr_alu_result, 0);
        chk("rst_wdata", b32.wr_wdata, 0);
        chk("rst_fwd", b32.fwd_hit, 0);
        chk("rst_wdata64", b64.wr_wdata, 0);

        step();
        rst_n = 1'b1;
        drv32(1'b1, 32'h0, 32'h1234, 5'd8, 1'b1, 1'b0, 3'd0);
        step();
        chk("load_wdata", b32.wr_wdata, 32'h1234);
        chk("load_regwr", b32.wr_RegWr, 1);
        chk("load_rw", b32.wr_Rw, 8);

        // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", b32.wr_valid, 0);
        chk("arst_wdata", b32.wr_wdata, 0);
        chk("arst_regwr", b32.wr_RegWr, 0);
        chk("arst_alu", b32.wr_alu_result, 0);
        b32.stall = 1'b1;
        step();
        chk("rst_ignores_stall", b32.wr_valid, 0);
        b32.stall = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_rst_wdata", b32.wr_wdata, 32'h1234);
        chk("post_rst_regwr", b32.wr_RegWr, 1);

        // sub-word extraction
        for (int i = 0; i < 7; i++) begin
            drv32(1'b1, 32'h80FF7F01, lv[i].alu, 5'd7, 1'b1, 1'b1, lv[i].ld);
            step();
            chk(lv[i].tag, b32.wr_wdata, lv[i].exp);
        end
        chk("alu_reg", b32.wr_alu_result, 32'd2);

        // stall hold
        drv32(1'b1, 32'h0, 32'hA, 5'd5, 1'b1, 1'b0, 3'd0);
        step();
        chk("stall_A_rw", b32.wr_Rw, 5);
        drv32(1'b1, 32'h0, 32'hB, 5'd6, 1'b1, 1'b0, 3'd0);
        b32.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_rw", b32.wr_Rw, 5);
            chk("stall_hold_wdata", b32.wr_wdata, 32'hA);
        end
        b32.stall = 1'b0;
        step();
        chk("stall_rel_rw", b32.wr_Rw, 6);
        chk("stall_rel_wdata", b32.wr_wdata, 32'hB);

        // flush wins over stall
        b32.stall = 1'b1; b32.flush = 1'b1;
        step();
        chk("flush_valid", b32.wr_valid, 0);
        chk("flush_regwr", b32.wr_RegWr, 0);
        b32.stall = 1'b0; b32.flush = 1'b0;

        // register 0 suppression
        drv32(1'b1, 32'h0, 32'h55, 5'd0, 1'b1, 1'b0, 3'd0);
        b32.fwd_src = {5'd3, 5'd0};
        step();
        chk("r0_valid", b32.wr_valid, 1);
        chk("r0_regwr", b32.wr_RegWr, 0);
        chk("r0_fwd0", b32.fwd_hit[0], 0);

        // forwarding
        drv32(1'b1, 32'h0, 32'h99, 5'd9, 1'b1, 1'b0, 3'd0);
        b32.fwd_src = {5'd9, 5'd3};
        step();
        chk("fwd_10", b32.fwd_hit, 2'b10);
        b32.fwd_src = {5'd9, 5'd9};
        #1;
        chk("fwd_11", b32.fwd_hit, 2'b11);
        drv32(1'b1, 32'h0, 32'h99, 5'd9, 1'b0, 1'b0, 3'd0);
        step();
        chk("fwd_noregwr", b32.fwd_hit, 2'b00);
        drv32(1'b1, 32'h0, 32'h99, 5'd9, 1'b1, 1'b0, 3'd0);
        b32.flush = 1'b1;
        step();
        chk("fwd_bubble", b32.fwd_hit, 2'b00);
        b32.flush = 1'b0;

        // 64-bit datapath
        drv64(64'h8877665544332211, 64'd7, 3'd2);
        step();
        chk("w64_lbu_off7", b64.wr_wdata, 64'h88);
        drv64(64'h8877665544332211, 64'd6, 3'd3);
        step();
        chk("w64_lh_off6", b64.wr_wdata, 64'hFFFFFFFFFFFF8877);
        drv64(64'h8877665544332211, 64'd7, 3'd1);
        step();
        chk("w64_lb_off7", b64.wr_wdata, 64'hFFFFFFFFFFFFFF88);
        drv64(64'h8877665544332211, 64'd3, 3'd4);
        step();
        chk("w64_lhu_off3", b64.wr_wdata, 64'h4433);
        drv64(64'h8877665544332211, 64'd0, 3'd0);
        step();
        chk("w64_word", b64.wr_wdata, 64'h8877665544332211);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_wr_stage.md
# mem_wr_stage

Parametrised MEM/WB pipeline stage register for the five-stage pipeline. It registers the memory-stage results and supports stall (hold) and flush (bubble insertion), tracked by a per-entry valid bit. It also produces the final write-back data, with little-endian sub-word load extraction and sign/zero extension. It reports write-back forwarding hits to the hazard unit for up to NUM_FWD source-register comparators.

## Interface
Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64; OFF_W = log2(DATA_W/8)
- REG_AW, 5, register-file address width
- NUM_FWD, 2, number of source-register forwarding comparators

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold all stage registers
- flush  in  1  load a bubble on the next edge
- mem_valid  in  1  memory-stage entry holds a real instruction
- mem_dout  in  DATA_W  data-memory read word
- mem_alu_result  in  DATA_W  ALU result / load address
- mem_Rw  in  REG_AW  destination register
- mem_RegWr  in  1  register-write enable
- mem_MemtoReg  in  1  1 = write-back from memory, 0 = from ALU
- mem_LdType  in  3  0 word, 1 lb, 2 lbu, 3 lh, 4 lhu; 5-7 treated as word
- fwd_src  in  NUM_FWD*REG_AW  packed source-register numbers; slot i = bits [i*REG_AW +: REG_AW]
- wr_valid  out  1  stage holds a real instruction
- wr_Rw  out  REG_AW  registered destination
- wr_RegWr  out  1  effective write enable = valid & RegWr & (Rw != 0)
- wr_alu_result  out  DATA_W  registered ALU result
- wr_wdata  out  DATA_W  final write-back value
- fwd_hit  out  NUM_FWD  bit i = wr_RegWr & (wr_Rw == slot i)

## Operation
- Registered state: valid, dout, alu_result, Rw, RegWr, MemtoReg, LdType.
- Each rising Clk edge, priority order:
  - flush: valid, RegWr and MemtoReg go to 0; the data fields load from the inputs (don't-care).
  - else stall: every register holds its value.
  - else: every register loads its mem_* input.
- flush and stall both high: flush wins. The stage becomes a bubble.
- A registered RegWr with Rw = 0 never asserts wr_RegWr. Register $0 is never written.
- Extraction is combinational from registered fields. off = alu_result[OFF_W-1:0]. Byte k = dout[8k+7:8k], little-endian.
  - lb/lbu: byte at index off; sign- or zero-extend to DATA_W.
  - lh/lhu: halfword at index off[OFF_W-1:1]; off[0] is ignored, with no misalign trap; sign- or zero-extend.
  - word: full dout.
- wr_wdata = MemtoReg ? extracted : alu_result.
- fwd_hit is combinational from registered state and the live fwd_src input. It is never asserted for a bubble or for Rw = 0.
- The forwarding value for the hazard unit is wr_wdata.

## Timing
- Rst_n low forces all registers to 0 immediately, with no clock required. Outputs during reset: wr_valid 0, wr_Rw 0, wr_RegWr 0, wr_alu_result 0, wr_wdata 0, fwd_hit all 0.
- Rst_n deassertion is taken synchronously by the system. The first capture happens on the first rising edge with Rst_n high.
- Latency is one cycle from mem_* to the registered outputs. wr_wdata and fwd_hit settle in the same cycle as the registers, with no extra stage.
- fwd_src to fwd_hit is a purely combinational path, in the same cycle.
- A stall held for N cycles keeps all outputs constant for N cycles. Inputs presented during the stall are lost unless they are still held when the stall releases.
- Reset asserted mid-stall or mid-flush clears the stage. stall and flush have no effect while Rst_n is low.

## Test plan
- Reset: drive Rst_n low mid-cycle after loading data. All outputs go to 0 asynchronously, before the next edge. After release with mem_valid=1, Rw=8, RegWr=1, MemtoReg=0, alu=0x1234, the next edge gives wr_wdata=0x1234 and wr_RegWr=1.
- Load extraction, DATA_W=32, dout=0x80FF7F01:
  - lb with off=3 gives 0xFFFFFF80.
  - lbu with off=3 gives 0x00000080.
  - lh with off=2 gives 0xFFFF80FF.
  - lhu with off=1 gives 0x00007F01.
  - word gives 0x80FF7F01.
- Stall/flush:
  - Load entry A (Rw=5), then assert stall for 3 cycles with entry B on the inputs. Outputs hold A for 3 cycles and show B one edge after the stall is released.
  - stall=1 together with flush=1 gives wr_valid=0 and wr_RegWr=0 after the edge.
- $0 suppression: Rw=0, RegWr=1, valid=1 gives wr_RegWr=0. With fwd_src slot 0 = 0, fwd_hit[0]=0.
- Forwarding: wr_Rw=9, wr_RegWr=1, fwd_src={9,3} (slot 1 = 9, slot 0 = 3) gives fwd_hit=2'b10. Changing slot 0 to 9 in the same cycle gives fwd_hit=2'b11 combinationally. A bubble gives 2'b00.
- DATA_W=64: dout=0x8877665544332211.
  - lbu with off=7 gives 0x88.
  - lh with off=6 gives 0xFFFFFFFFFFFF8877.
